// File: rtl/ddr4_v2_2_20_axi_fifo_prog_if.sv
// FIFO request/response bundle for ddr4_v2_2_20_axi_fifo_prog.
// master drives requests and write data; slave returns head data and status.
interface ddr4_v2_2_20_axi_fifo_prog_if #(
  parameter int C_WIDTH  = 8,
  parameter int C_AWIDTH = 4
);
  logic               wr_en;
  logic               rd_en;
  logic [C_WIDTH-1:0] din;
  logic [C_WIDTH-1:0] dout;
  logic [C_AWIDTH:0]  count;
  logic               full;
  logic               a_full;
  logic               empty;
  logic               a_empty;
  logic               overflow;
  logic               underflow;

  modport master (
    output wr_en, rd_en, din,
    input  dout, count, full, a_full,
    input  empty, a_empty, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, din,
    output dout, count, full, a_full,
    output empty, a_empty, overflow, underflow
  );
endinterface

// File: rtl/ddr4_v2_2_20_axi_fifo_prog.sv
// Shift-register FIFO, first-word fall-through, programmable flag levels.
// Define DDR4_AXI_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module ddr4_v2_2_20_axi_fifo_prog #(
  parameter int C_WIDTH         = 8,
  parameter int C_AWIDTH        = 4,
  parameter int C_DEPTH         = 16,
  parameter int C_AFULL_THRESH  = C_DEPTH - 2,
  parameter int C_AEMPTY_THRESH = 1
) (
  input logic clk,
  input logic rst_n,
  ddr4_v2_2_20_axi_fifo_prog_if.slave bus
);
  localparam logic [C_AWIDTH:0] DEPTH_C =
    (C_AWIDTH+1)'(C_DEPTH);
  localparam logic [C_AWIDTH:0] AFULL_C =
    (C_AWIDTH+1)'(C_AFULL_THRESH);
  localparam logic [C_AWIDTH:0] AEMPTY_C =
    (C_AWIDTH+1)'(C_AEMPTY_THRESH);

  logic [C_WIDTH-1:0]  mem [C_DEPTH];
  logic [C_AWIDTH:0]   count_q;
  logic [C_AWIDTH:0]   count_nxt;
  logic [C_AWIDTH-1:0] head_idx;
  logic                wr_acc;
  logic                rd_acc;

  // a write into a full FIFO is allowed only when a read frees the slot
  assign wr_acc = bus.wr_en &&
                  ((count_q < DEPTH_C) || bus.rd_en);
  assign rd_acc = bus.rd_en && (count_q != '0);

  always_comb begin
    count_nxt = count_q;
    unique case (1'b1)
      (wr_acc && !rd_acc): count_nxt = count_q + 1'b1;
      (rd_acc && !wr_acc): count_nxt = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_nxt;
    end
  end

  // storage is not reset; count alone decides what is valid
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = C_DEPTH-1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= bus.din;
    end
  end

  assign head_idx = C_AWIDTH'(count_q - 1'b1);

  assign bus.dout    = (count_q == '0) ? '0 : mem[head_idx];
  assign bus.count   = count_q;
  assign bus.full    = (count_q == DEPTH_C);
  assign bus.empty   = (count_q == '0);
  assign bus.a_full  = (count_q >= AFULL_C);
  assign bus.a_empty = (count_q <= AEMPTY_C);

`ifdef DDR4_AXI_FIFO_ERR_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr_en && !wr_acc) ovf_q <= 1'b1;
      if (bus.rd_en && !rd_acc) udf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: doc/ddr4_v2_2_20_axi_fifo_prog.md
DDR4_V2_2_20_AXI_FIFO_PROG -- requirements
Module: ddr4_v2_2_20_axi_fifo_prog

Interface
REQ-001 Parameter C_WIDTH, default 8: data width in bits.
REQ-002 Parameter C_AWIDTH, default 4: address width, with C_DEPTH <= 2**C_AWIDTH.
REQ-003 Parameter C_DEPTH, default 16: number of entries, minimum 2.
REQ-004 Parameter C_AFULL_THRESH, default C_DEPTH-2: almost-full level, range 1..C_DEPTH-1.
REQ-005 Parameter C_AEMPTY_THRESH, default 1: almost-empty level, range 0..C_DEPTH-2, below C_AFULL_THRESH.
REQ-006 clk  input  1  system clock; all logic is on the rising edge.
REQ-007 rst_n  input  1  reset; synchronous, active-low.
REQ-008 wr_en  input  1  write request.
REQ-009 rd_en  input  1  read request (pop the head entry).
REQ-010 din  input  C_WIDTH  write data.
REQ-011 dout  output  C_WIDTH  head entry, first-word fall-through.
REQ-012 count  output  C_AWIDTH+1  current occupancy, 0..C_DEPTH.
REQ-013 full, a_full, empty, a_empty  output  1 each  status flags.
REQ-014 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 Storage SHALL be a shift-register array: an accepted write shifts every entry up by one and loads din at index 0; the array has no reset.
REQ-016 dout SHALL be entry[count-1] when count>0, and all-zero when count==0.
REQ-017 A write SHALL be accepted when wr_en=1 and either count<C_DEPTH, or count==C_DEPTH and rd_en=1.
REQ-018 A read SHALL be accepted when rd_en=1 and count>0.
REQ-019 count SHALL change on each clk edge as follows: write-only accepted gives +1; read-only accepted gives -1; both accepted, or neither accepted, gives no change.
REQ-020 On simultaneous wr_en and rd_en with count==0, the write SHALL be accepted, the read ignored, and count SHALL become 1.
REQ-021 On simultaneous accepted write and read with count==C_DEPTH, count SHALL stay at C_DEPTH and the oldest entry SHALL be discarded.
REQ-022 A write accepted at edge N SHALL appear on dout after edge N when the FIFO was empty (one-cycle write-to-read latency).
REQ-023 The flags SHALL be decoded combinationally from registered count, as follows:
- full = (count==C_DEPTH)
- empty = (count==0)
- a_full = (count>=C_AFULL_THRESH)
- a_empty = (count<=C_AEMPTY_THRESH)
REQ-024 Rejected requests SHALL have no effect:
- wr_en while full without rd_en leaves storage and count unchanged;
- rd_en while empty leaves count unchanged.
REQ-025 All count arithmetic SHALL be C_AWIDTH+1 bits wide and SHALL never wrap.

Reset
REQ-026 While rst_n=0 at a clk edge, count SHALL be set to 0, giving:
- empty=1 and a_empty=1;
- full=0 and a_full=0;
- dout all-zero.
REQ-027 Reset SHALL clear overflow and underflow to 0.
REQ-028 Reset SHALL take priority over wr_en and rd_en in the same cycle.
REQ-029 Assertion of reset mid-operation SHALL discard all content logically.
REQ-030 The first write after reset is released SHALL be accepted normally.

Configuration
REQ-031 With macro DDR4_AXI_FIFO_ERR_EN defined, error flags SHALL behave as follows:
- overflow is set one cycle after a rejected write (REQ-024) and holds until reset;
- underflow is set one cycle after a rejected read (REQ-024) and holds until reset.
REQ-032 Without DDR4_AXI_FIFO_ERR_EN, overflow and underflow SHALL be constant 0, no error registers SHALL be present, and all other behaviour SHALL be identical.

Verification (C_WIDTH=8, C_DEPTH=16, C_AFULL_THRESH=14, C_AEMPTY_THRESH=1)
REQ-033 Reset, then write 0x01..0x10 on consecutive cycles:
- count reaches 16 with full=1;
- a_full first rises when count=14;
- dout=0x01 from the cycle after the first write.
REQ-034 From full, pulse wr_en with din=0xAA and rd_en=0:
- count stays 16 and content is unchanged;
- overflow=1 next cycle with the macro, 0 without it.
REQ-035 From full, assert wr_en and rd_en together for one cycle with din=0xBB:
- count stays 16;
- dout changes from 0x01 to 0x02;
- 0xBB is the newest entry.
REQ-036 Drain all entries, then assert rd_en alone:
- count stays 0, empty=1, dout=0x00;
- underflow=1 with the macro.
REQ-037 Empty FIFO, assert wr_en and rd_en together with din=0x5C:
- count becomes 1;
- dout=0x5C, empty=0, a_empty=1.
REQ-038 With count=8, drive rst_n=0 for one cycle together with wr_en=1:
- next cycle count=0, empty=1, error flags cleared;
- a subsequent write of 0x33 gives dout=0x33.
